// File: rtl/aurora_link_frame_check.sv
// aurora_link_frame_check
//
// Receive-side pattern checker for Aurora link hardware test. It sits on the
// LocalLink RX user interface and checks every valid word against a walking-one
// sequence that rotates right one place per valid word. It also checks SOF/EOF
// framing and REM, and keeps saturating error counters and a wrapping frame
// counter.
//
// Optional feature: define AURORA_LINK_FRAME_CHECK_ONEHOT_EN to also flag any
// valid word that does not have exactly one bit set, including the seeding
// word.
//
// Ports (bit 0 is the MSB on all vectors):
//   user_clk_i           user clock, all logic on its rising edge
//   reset_i              asynchronous active-high reset
//   rx_d_i[0:15]         received data
//   rx_rem_i             remainder, 1 = both bytes valid
//   rx_sof_n_i           start of frame, active-low
//   rx_eof_n_i           end of frame, active-low
//   rx_src_rdy_n_i       beat valid, active-low (checker always accepts)
//   data_err_count_o     data mismatches, saturates at 255
//   framing_err_count_o  framing/REM violations, saturates at 255
//   frame_count_o        good EOFs, wraps modulo 2^16
//   error_o              one-cycle pulse for any error on a beat
module aurora_link_frame_check (
    input  logic        user_clk_i,
    input  logic        reset_i,
    input  logic [0:15] rx_d_i,
    input  logic        rx_rem_i,
    input  logic        rx_sof_n_i,
    input  logic        rx_eof_n_i,
    input  logic        rx_src_rdy_n_i,
    output logic [0:7]  data_err_count_o,
    output logic [0:7]  framing_err_count_o,
    output logic [0:15] frame_count_o,
    output logic        error_o
);

    typedef enum logic [0:0] {StIdle, StInFrame} state_e;

    state_e      state_q, state_d;
    logic        seeded_q;
    logic [0:15] expected_q, expected_d;
    logic [0:7]  data_err_cnt_q;
    logic [0:7]  framing_err_cnt_q;
    logic [0:15] frame_cnt_q;
    logic        error_q;

    logic        valid;
    logic        sof;
    logic        eof;
    logic        onehot_err;
    logic        mismatch;
    logic        data_err;
    logic        framing_err;
    logic        frame_done;

    always_comb begin
        valid = ~rx_src_rdy_n_i;
        sof   = ~rx_sof_n_i;
        eof   = ~rx_eof_n_i;

`ifdef AURORA_LINK_FRAME_CHECK_ONEHOT_EN
        // x & (x - 1) clears the lowest set bit; nonzero leftover means >1 bit set
        onehot_err = (rx_d_i == 16'h0000) || ((rx_d_i & (rx_d_i - 16'd1)) != 16'h0000);
`else
        onehot_err = 1'b0;
`endif

        // No compare on the seeding beat; afterwards the sequence follows
        // expected_q only, so one corrupt word yields exactly one error.
        mismatch   = seeded_q && (rx_d_i != expected_q);
        data_err   = valid && (mismatch || onehot_err);
        expected_d = seeded_q ? {expected_q[15], expected_q[0:14]} : {rx_d_i[15], rx_d_i[0:14]};

        // SOF outside a frame is required; SOF inside a frame means the previous
        // frame never ended. All conditions fold into one error per beat.
        framing_err = valid && (((state_q == StIdle) && !sof) ||
                                ((state_q == StInFrame) && sof) ||
                                (eof && !rx_rem_i));
        frame_done  = valid && eof && !framing_err;

        state_d = state_q;
        if (valid) begin
            if (eof) begin
                state_d = StIdle;
            end else if (sof) begin
                state_d = StInFrame;
            end
        end
    end

    always_ff @(posedge user_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q           <= StIdle;
            seeded_q          <= 1'b0;
            expected_q        <= 16'h0001;
            data_err_cnt_q    <= 8'h00;
            framing_err_cnt_q <= 8'h00;
            frame_cnt_q       <= 16'h0000;
            error_q           <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= data_err || framing_err;
            if (valid) begin
                seeded_q   <= 1'b1;
                expected_q <= expected_d;
            end
            if (data_err && (data_err_cnt_q != 8'hFF)) begin
                data_err_cnt_q <= data_err_cnt_q + 8'd1;
            end
            if (framing_err && (framing_err_cnt_q != 8'hFF)) begin
                framing_err_cnt_q <= framing_err_cnt_q + 8'd1;
            end
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign data_err_count_o    = data_err_cnt_q;
    assign framing_err_count_o = framing_err_cnt_q;
    assign frame_count_o       = frame_cnt_q;
    assign error_o             = error_q;

endmodule

// File: tb/tb_aurora_link_frame_check.sv
// Self-checking bench for aurora_link_frame_check. Directed beats push the
// expected counter/ERROR state onto a scoreboard queue; after the clock edge
// that registers the beat, the entry is popped and compared.
module tb_aurora_link_frame_check;

    logic        clk;
    logic        rst;
    logic [0:15] rx_d;
    logic        rx_rem;
    logic        rx_sof_n;
    logic        rx_eof_n;
    logic        rx_src_rdy_n;
    logic [0:7]  data_err_count;
    logic [0:7]  framing_err_count;
    logic [0:15] frame_count;
    logic        error;

    aurora_link_frame_check dut (
        .user_clk_i          (clk),
        .reset_i             (rst),
        .rx_d_i              (rx_d),
        .rx_rem_i            (rx_rem),
        .rx_sof_n_i          (rx_sof_n),
        .rx_eof_n_i          (rx_eof_n),
        .rx_src_rdy_n_i      (rx_src_rdy_n),
        .data_err_count_o    (data_err_count),
        .framing_err_count_o (framing_err_count),
        .frame_count_o       (frame_count),
        .error_o             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  de;
        logic [7:0]  fe;
        logic [15:0] fc;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_de   = 8'd0;
    logic [7:0]  exp_fe   = 8'd0;
    logic [15:0] exp_fc   = 16'd0;

`ifdef AURORA_LINK_FRAME_CHECK_ONEHOT_EN
    localparam logic ONEHOT = 1'b1;
`else
    localparam logic ONEHOT = 1'b0;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pop one scoreboard entry and compare against the DUT outputs.
    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_data_err"}, {8'h00, data_err_count}, {8'h00, e.de});
        chk({tag, "_frm_err"}, {8'h00, framing_err_count}, {8'h00, e.fe});
        chk({tag, "_frames"}, frame_count, e.fc);
        chk({tag, "_error"}, {15'd0, error}, {15'd0, e.err});
    endtask

    // Drive one cycle (valid or gap) at negedge; de/fe/fc are the expected
    // increments the beat should cause.
    task automatic cycle(input string tag, input logic vld, input logic [15:0] d,
                         input logic sof_n, input logic eof_n, input logic rem,
                         input logic de, input logic fe, input logic fc);
        exp_t e;
        rx_src_rdy_n = ~vld;
        rx_d         = d;
        rx_sof_n     = sof_n;
        rx_eof_n     = eof_n;
        rx_rem       = rem;
        if (de && exp_de != 8'hFF) exp_de = exp_de + 8'd1;
        if (fe && exp_fe != 8'hFF) exp_fe = exp_fe + 8'd1;
        if (fc) exp_fc = exp_fc + 16'd1;
        e.de  = exp_de;
        e.fe  = exp_fe;
        e.fc  = exp_fc;
        e.err = de | fe;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare(tag);
        rx_src_rdy_n = 1'b1;
    endtask

    task automatic beat(input string tag, input logic [15:0] d, input logic sof_n,
                        input logic eof_n, input logic rem, input logic de,
                        input logic fe, input logic fc);
        cycle(tag, 1'b1, d, sof_n, eof_n, rem, de, fe, fc);
    endtask

    // Garbage on the bus with valid deasserted must be ignored.
    task automatic gap(input string tag);
        cycle(tag, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_de = 8'd0;
        exp_fe = 8'd0;
        exp_fc = 16'd0;
    endtask

    initial begin
        rst          = 1'b1;
        rx_d         = 16'h0000;
        rx_rem       = 1'b1;
        rx_sof_n     = 1'b1;
        rx_eof_n     = 1'b1;
        rx_src_rdy_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_data_err", {8'h00, data_err_count}, 16'd0);
        chk("rst_frm_err", {8'h00, framing_err_count}, 16'd0);
        chk("rst_frames", frame_count, 16'd0);
        chk("rst_error", {15'd0, error}, 16'd0);

        // Clean frame
        beat("clean_sof", 16'h0001, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        beat("clean_mid", 16'h8000, 1'b1, 1'b1, 1'b1, 0, 0, 0);
        beat("clean_eof", 16'h4000, 1'b1, 1'b0, 1'b1, 0, 0, 1);

        // Single corrupt word: the sequence continues from expected, not RX_D
        do_reset();
        beat("bad_seed", 16'h0001, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        beat("bad_word", 16'h0400, 1'b1, 1'b1, 1'b1, 1, 0, 0);
        beat("bad_next", 16'h4000, 1'b1, 1'b0, 1'b1, 0, 0, 1);

        // Framing: missing EOF, then EOF with REM=0 (no frame count)
        beat("frm_sof", 16'h2000, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        beat("frm_mid", 16'h1000, 1'b1, 1'b1, 1'b1, 0, 0, 0);
        beat("frm_sof2", 16'h0800, 1'b0, 1'b1, 1'b1, 0, 1, 0);
        beat("frm_rem0", 16'h0400, 1'b1, 1'b0, 1'b0, 0, 1, 0);

        // Gaps carrying garbage, plus single-beat frames
        gap("gap0");
        beat("single0", 16'h0200, 1'b0, 1'b0, 1'b1, 0, 0, 1);
        gap("gap1");
        beat("single1", 16'h0100, 1'b0, 1'b0, 1'b1, 0, 0, 1);
        gap("gap2");
        gap("gap3");
        beat("single2", 16'h0080, 1'b0, 1'b0, 1'b1, 0, 0, 1);

        // Saturation: 300 mismatching in-frame beats
        beat("sat_sof", 16'h0040, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            beat("sat", 16'h0000, 1'b1, 1'b1, 1'b1, 1, 0, 0);
        end
        chk("sat_final", {8'h00, data_err_count}, 16'd255);

        // Asynchronous reset mid-frame: outputs clear before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("arst_data_err", {8'h00, data_err_count}, 16'd0);
        chk("arst_frm_err", {8'h00, framing_err_count}, 16'd0);
        chk("arst_frames", frame_count, 16'd0);
        chk("arst_error", {15'd0, error}, 16'd0);
        #1 rst = 1'b0;
        exp_de = 8'd0;
        exp_fe = 8'd0;
        exp_fc = 16'd0;
        @(negedge clk);
        // First beat after reset is non-SOF: framing error, but it re-seeds
        beat("post_rst_nosof", 16'h0010, 1'b1, 1'b1, 1'b1, 0, 1, 0);
        beat("post_rst_single", 16'h0008, 1'b0, 1'b0, 1'b1, 0, 0, 1);

        // Non-one-hot words that still follow the sequence
        do_reset();
        beat("oh_seed", 16'h0003, 1'b0, 1'b0, 1'b1, ONEHOT, 0, 1);
        beat("oh_next", 16'h8001, 1'b0, 1'b0, 1'b1, ONEHOT, 0, 1);
        chk("oh_total", {8'h00, data_err_count}, ONEHOT ? 16'd2 : 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aurora_link_frame_check.md
# aurora_link_frame_check

Receive-side pattern checker for hardware test of the Aurora link. It sits on the LocalLink RX user interface of the Aurora core, opposite the frame generator on the far end's TX interface. It checks every valid word against the walking-one sequence the generator produces (a single high bit rotating right one place per valid word). It also checks SOF/EOF framing and REM, and exposes saturating error counters plus a frame counter for chipscope or register readout.

## Interface
- No parameters; the data width is fixed at 16 bits with a 1-bit REM.
- USER_CLK  in  1  user clock from the Aurora core; all logic is on its rising edge.
- RESET  in  1  reset, asynchronous and active-high.
- RX_D  in  [0:15]  received data; bit 0 is the MSB.
- RX_REM  in  1  remainder; 1 means both bytes are valid.
- RX_SOF_N  in  1  start of frame, active-low.
- RX_EOF_N  in  1  end of frame, active-low.
- RX_SRC_RDY_N  in  1  beat valid, active-low. There is no destination-ready signal; the checker always accepts.
- DATA_ERR_COUNT  out  [0:7]  data mismatches; saturates at 255.
- FRAMING_ERR_COUNT  out  [0:7]  framing and REM violations; saturates at 255.
- FRAME_COUNT  out  [0:15]  good EOFs received; wraps modulo 2^16.
- ERROR  out  1  one-cycle pulse for any error detected on a beat.

## Operation
- Valid beat means RX_SRC_RDY_N=0. All inputs are ignored when RX_SRC_RDY_N=1.
- **Data check**
  - seeded_r is cleared by reset.
  - First valid beat after reset: no compare. expected_r <= rotr(RX_D) and seeded_r <= 1.
  - Each later valid beat: mismatch if RX_D != expected_r.
  - Each later valid beat: expected_r <= rotr(expected_r). The rotation always follows expected_r, never the received word, so one corrupt word gives exactly one error.
  - rotr(x) = {x[15], x[0:14]}. Example: 0x0001 -> 0x8000 -> 0x4000.
  - The data check runs on every valid beat, inside or outside a frame.
- **Framing FSM**: two states, IDLE and IN_FRAME; reset state is IDLE.
  - IDLE, valid beat, SOF=0, EOF=1: go to IN_FRAME.
  - IDLE, valid beat, SOF=0, EOF=0: single-cycle frame; stay in IDLE.
  - IDLE, valid beat, SOF=1: framing error. If EOF=0, stay in IDLE; if EOF=1, stay in IDLE and count the error only (no frame count).
  - IN_FRAME, valid beat, SOF=1, EOF=1: stay in IN_FRAME.
  - IN_FRAME, valid beat, EOF=0 and SOF=1: end of frame; go to IDLE.
  - IN_FRAME, valid beat, SOF=0: framing error (previous frame never ended). The beat is treated as a new SOF, with the same EOF handling as in IDLE.
  - REM check: any beat with EOF=0 and RX_REM=0 is a framing error.
- **Counting**
  - At most one framing-error increment per beat, even when several framing conditions are true.
  - FRAME_COUNT increments on each EOF beat that carries no framing error.
  - A data error and a framing error on the same beat increment both counters; ERROR pulses once.
  - Counters hold at 255; they never wrap.

## Timing
- Outputs are registered. Counters and ERROR update on the first USER_CLK edge after the offending beat is sampled, giving 1-cycle latency.
- Reset values: DATA_ERR_COUNT=0, FRAMING_ERR_COUNT=0, FRAME_COUNT=0, ERROR=0, FSM=IDLE, seeded_r=0, expected_r=0x0001.
- Reset asserted mid-frame clears all state immediately, with no clock needed. The first valid beat after reset is then checked:
  - it re-seeds the data check;
  - a non-SOF first beat counts as a framing error.
- Back-to-back valid beats are supported every cycle. Gaps in RX_SRC_RDY_N do not advance expected_r.

## Configuration
- Macro: AURORA_LINK_FRAME_CHECK_ONEHOT_EN.
- Defined: every valid beat is also checked for exactly one set bit in RX_D, including the seeding beat. A non-one-hot word is a data error, counted once per beat even if it also mismatches. A non-one-hot seed word still seeds expected_r.
- Undefined: no one-hot check. Only the sequence compare applies, and the seeding beat never errors.

## Test plan
- Clean frame:
  - Stimulus: reset, then valid beats 0x0001 (SOF), 0x8000, 0x4000 (EOF, REM=1).
  - Response: DATA_ERR_COUNT=0, FRAMING_ERR_COUNT=0, FRAME_COUNT=1, ERROR never asserted.
- Single corrupt word:
  - Stimulus: after seed 0x0001, send 0x0400 where 0x8000 is expected, then 0x4000.
  - Response: DATA_ERR_COUNT=1; ERROR pulses one cycle after the bad beat; 0x4000 then passes.
- Framing errors:
  - Stimulus: SOF, data, then SOF again without EOF, then EOF with REM=0.
  - Response: FRAMING_ERR_COUNT=2 (missing EOF, and the REM violation, with no frame count for that EOF), FRAME_COUNT=0.
- Gaps and single-cycle frames:
  - Stimulus: interleave RX_SRC_RDY_N=1 cycles carrying garbage data and SOF/EOF low, plus SOF+EOF single-beat frames.
  - Response: garbage is ignored, expected_r does not advance, FRAME_COUNT counts each single-beat frame, no errors.
- Saturation and reset:
  - Stimulus: 300 mismatching beats, then RESET pulsed mid-frame with no clock edge.
  - Response: DATA_ERR_COUNT=255; after the reset all outputs read 0 immediately.
- Macro defined:
  - Stimulus: seed beat 0x0003, then 0x8001.
  - Response: DATA_ERR_COUNT=2 (one per beat). With the macro undefined: DATA_ERR_COUNT=0.
